// File: rtl/debounce_edge_det_pkg.sv
// Shared types and defaults for the debounce / edge-detect stage.
// State encodings double as output decode: bit0 = busy, bit1 = level.
package debounce_edge_det_pkg;

  typedef logic [1:0] state_t;

  localparam state_t STABLE_LOW  = 2'd0;
  localparam state_t CHECK_HIGH  = 2'd1;
  localparam state_t STABLE_HIGH = 2'd2;
  localparam state_t CHECK_LOW   = 2'd3;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 3;
  localparam int DEF_GLITCH_W        = 8;

  function automatic logic is_check(state_t st);
    return st[0];
  endfunction

  function automatic logic level_of(state_t st);
    return st[1];
  endfunction

endpackage

// File: rtl/debounce_edge_det_sync_chain.sv
// Parameterised reset-to-zero flop chain for asynchronous inputs.
// q is d delayed by SYNC_STAGES rising edges.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r;

  // shift d through the chain, clearing on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r <= '0;
    else          r <= {r[SYNC_STAGES-2:0], d};
  end

  assign q = r[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_det.sv
// Synchronise, debounce and edge-detect one bit.
// Aborted checks are tallied in a saturating glitch counter.
module debounce_edge_det
  import debounce_edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int GLITCH_W        = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_input,
  output logic                o_output,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_busy,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic                s;
  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_n;
  logic                rise_n;
  logic                fall_n;
  logic                abort;
  logic                rise;
  logic                fall;
  logic [GLITCH_W-1:0] glitch;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (i_input),
    .q      (s)
  );

  // next-state: enter a check on a change, commit or abort it
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      STABLE_LOW: begin
        if (s) begin
          state_n = CHECK_HIGH;
          cnt_n   = ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_n = CHECK_LOW;
          cnt_n   = ONE;
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
          abort   = 1'b1;
        end else if (cnt == LAST) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
          abort   = 1'b1;
        end else if (cnt == LAST) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = STABLE_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM, counter and pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // saturating count of aborted checks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      glitch <= '0;
    else if (abort && (glitch != '1))
      glitch <= glitch + GLITCH_W'(1);
  end

  assign o_output     = level_of(state);
  assign o_busy       = is_check(state);
  assign o_rise       = rise;
  assign o_fall       = fall;
  assign o_glitch_cnt = glitch;

endmodule
